// File: rtl/dd_merge_arbiter_pkg.sv
// Shared join-pipeline definitions used by the merge arbiter and its users.
//   SERIAL_W : serial number width
//   TAG_W    : tuple tag width
//   DATA_W   : default tuple data width
//   tuple_t  : full tuple with sideband flags
package dd_merge_arbiter_pkg;

  localparam int SERIAL_W = 64;
  localparam int TAG_W    = 32;
  localparam int DATA_W   = 64;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [TAG_W-1:0]    tag;
    logic [SERIAL_W-1:0] serialnum;
    logic                was_joined;
    logic                last_processed;
  } tuple_t;

endpackage

// File: rtl/dd_merge_arbiter_rr_grant.sv
// Cyclic priority encoder: picks the first set bit of elig, searching
// upward from rr_ptr and wrapping at NUM_IN. Purely combinational.
//   elig      : eligible request vector
//   rr_ptr    : index searched first
//   grant     : one-hot grant (zero when nothing is eligible)
//   grant_idx : binary index of the granted bit
//   any_grant : at least one bit eligible
module rr_grant #(
  parameter int NUM_IN = 2,
  parameter int PW     = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] elig,
  input  logic [PW-1:0]     rr_ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [PW-1:0]     grant_idx,
  output logic              any_grant
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      // rr_ptr < NUM_IN and k < NUM_IN, so one subtraction wraps it
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_IN)) sum = sum - (PW+1)'(NUM_IN);
      idx = sum[PW-1:0];
      if (!any_grant && elig[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/dd_merge_arbiter.sv
// Round-robin merge of NUM_IN tuple streams into one registered output
// slot, with end-of-stream alignment: each input's last_processed marker
// parks that input until every input has delivered its own, and only the
// tuple completing the set leaves with out_last_processed=1.
//   clk, resetn        : clock, async active-low reset
//   in_*               : per-input tuple streams (valid/ready handshake)
//   out_*              : registered merged stream, out_src = source index
module dd_merge_arbiter
  import dd_merge_arbiter_pkg::*;
#(
  parameter int INPUT_SIZE = 64,
  parameter int NUM_IN     = 2
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  output logic [NUM_IN-1:0]                    in_ready,
  input  logic [NUM_IN-1:0][INPUT_SIZE-1:0]    in_data,
  input  logic [NUM_IN-1:0][TAG_W-1:0]         in_tag,
  input  logic [NUM_IN-1:0]                    in_valid,
  input  logic [NUM_IN-1:0]                    in_last_processed,
  input  logic [NUM_IN-1:0][SERIAL_W-1:0]      in_serialnum,
  input  logic [NUM_IN-1:0]                    in_was_joined,
  input  logic                                 out_ready,
  output logic [INPUT_SIZE-1:0]                out_data,
  output logic [TAG_W-1:0]                     out_tag,
  output logic                                 out_valid,
  output logic                                 out_last_processed,
  output logic [SERIAL_W-1:0]                  out_serialnum,
  output logic                                 out_was_joined,
  output logic [$clog2(NUM_IN)-1:0]            out_src
);

  localparam int PW = $clog2(NUM_IN);

  logic              load_en;
  logic              any_grant;
  logic              fire;
  logic              phase_end;
  logic [NUM_IN-1:0] elig;
  logic [NUM_IN-1:0] grant;
  logic [NUM_IN-1:0] done_mask;
  logic [NUM_IN-1:0] done_next;
  logic [PW-1:0]     grant_idx;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     rr_next;

  // Slot can take a tuple when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;

  // Inputs that already sent their end marker wait for the others.
  assign elig = in_valid & ~done_mask;

  rr_grant #(
    .NUM_IN (NUM_IN)
  ) u_rr_grant (
    .elig      (elig),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign fire      = load_en && any_grant;
  assign in_ready  = fire ? grant : '0;
  assign done_next = done_mask | (grant & in_last_processed);
  assign phase_end = &done_next;
  assign rr_next   = (grant_idx == PW'(NUM_IN-1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid          <= 1'b0;
      out_last_processed <= 1'b0;
      out_data           <= '0;
      out_tag            <= '0;
      out_serialnum      <= '0;
      out_was_joined     <= 1'b0;
      out_src            <= '0;
      rr_ptr             <= '0;
      done_mask          <= '0;
    end else if (fire) begin
      out_valid      <= 1'b1;
      out_data       <= in_data[grant_idx];
      out_tag        <= in_tag[grant_idx];
      out_serialnum  <= in_serialnum[grant_idx];
      out_was_joined <= in_was_joined[grant_idx];
      out_src        <= grant_idx;
      rr_ptr         <= rr_next;
      if (phase_end) begin
        // Final marker of the phase: emit merged marker, start a new phase.
        out_last_processed <= 1'b1;
        done_mask          <= '0;
      end else begin
        out_last_processed <= 1'b0;
        done_mask          <= done_next;
      end
    end else if (load_en) begin
      out_valid          <= 1'b0;
      out_last_processed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dd_merge_arbiter.sv
module tb_dd_merge_arbiter;
  import dd_merge_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int DW = 64;

  logic                    clk = 1'b0;
  logic                    resetn = 1'b0;
  logic [N-1:0]            in_ready;
  logic [N-1:0][DW-1:0]    in_data;
  logic [N-1:0][31:0]      in_tag;
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_last_processed;
  logic [N-1:0][63:0]      in_serialnum;
  logic [N-1:0]            in_was_joined;
  logic                    out_ready;
  logic [DW-1:0]           out_data;
  logic [31:0]             out_tag;
  logic                    out_valid;
  logic                    out_last_processed;
  logic [63:0]             out_serialnum;
  logic                    out_was_joined;
  logic [$clog2(N)-1:0]    out_src;

  dd_merge_arbiter #(.INPUT_SIZE(DW), .NUM_IN(N)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .in_tag             (in_tag),
    .in_valid           (in_valid),
    .in_last_processed  (in_last_processed),
    .in_serialnum       (in_serialnum),
    .in_was_joined      (in_was_joined),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_tag            (out_tag),
    .out_valid          (out_valid),
    .out_last_processed (out_last_processed),
    .out_serialnum      (out_serialnum),
    .out_was_joined     (out_was_joined),
    .out_src            (out_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] serial;
    int          src;
    bit          last;
  } obs_t;

  typedef struct {
    int          test;
    int          port;
    logic [63:0] in_serial;
    bit          in_last;
    logic [63:0] exp_serial;
    int          exp_src;
    bit          exp_last;
  } vec_t;

  int     n_chk = 0;
  int     n_fail = 0;
  tuple_t srcq [N][$];
  bit     en [N];
  bit     pres [N];
  obs_t   outlog [$];
  vec_t   vt [$];

  // Reference state: what the output slot should hold, whose turn it is,
  // and which inputs have already delivered their end marker this phase.
  bit     mv;
  tuple_t mt;
  int     msrc;
  bit     mlast;
  int     mptr;
  bit     mdone [N];

  function automatic tuple_t mk(input logic [63:0] s, input bit l);
    tuple_t t;
    t.data           = ~s ^ {s[31:0], s[63:32]};
    t.tag            = s[31:0] ^ 32'hA5A5_0F0F;
    t.serialnum      = s;
    t.was_joined     = s[0];
    t.last_processed = l;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    mv = 1'b0; mlast = 1'b0; mptr = 0; msrc = 0;
    for (int i = 0; i < N; i++) mdone[i] = 1'b0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      pres[i] = en[i] && (srcq[i].size() > 0);
      in_valid[i] = pres[i];
      if (srcq[i].size() > 0) begin
        in_data[i]           = srcq[i][0].data;
        in_tag[i]            = srcq[i][0].tag;
        in_serialnum[i]      = srcq[i][0].serialnum;
        in_was_joined[i]     = srcq[i][0].was_joined;
        in_last_processed[i] = srcq[i][0].last_processed;
      end else begin
        in_data[i] = '0; in_tag[i] = '0; in_serialnum[i] = '0;
        in_was_joined[i] = 1'b0; in_last_processed[i] = 1'b0;
      end
    end
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  // One clock: check outputs against the reference, advance both.
  task automatic tick();
    int g;
    bit load;
    bit alldone;
    logic [N-1:0] er;
    load = !mv || out_ready;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (mptr + k) % N;
      if (g < 0 && pres[idx] && !mdone[idx]) g = idx;
    end
    er = '0;
    if (load && g >= 0) er = N'(1) << g;
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, mv);
    if (mv) begin
      chk("out_serialnum", out_serialnum, mt.serialnum);
      chk("out_src", out_src, msrc);
      chk("out_last_processed", out_last_processed, mlast);
      chk("out_data", out_data, mt.data);
      chk("out_tag", out_tag, mt.tag);
      chk("out_was_joined", out_was_joined, mt.was_joined);
    end
    if (out_valid && out_ready)
      outlog.push_back('{out_serialnum, int'(out_src), out_last_processed});
    @(posedge clk);
    #1;
    if (load) begin
      if (g >= 0) begin
        mt = srcq[g].pop_front();
        mv = 1'b1;
        msrc = g;
        mptr = (g + 1) % N;
        if (mt.last_processed) mdone[g] = 1'b1;
        alldone = 1'b1;
        for (int i = 0; i < N; i++) if (!mdone[i]) alldone = 1'b0;
        mlast = alldone;
        if (alldone) for (int i = 0; i < N; i++) mdone[i] = 1'b0;
      end else begin
        mv = 1'b0;
      end
    end
    drive();
    #1;
  endtask

  task automatic run_until(input int n, input int budget);
    int c;
    c = 0;
    while (outlog.size() < n && c < budget) begin
      tick();
      c++;
    end
    if (outlog.size() < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout: got %0d outputs, required %0d", outlog.size(), n);
    end
  endtask

  task automatic load_test(input int t);
    outlog.delete();
    foreach (vt[k])
      if (vt[k].test == t) srcq[vt[k].port].push_back(mk(vt[k].in_serial, vt[k].in_last));
  endtask

  task automatic compare_test(input int t, input string nm);
    int j;
    j = 0;
    foreach (vt[k]) begin
      if (vt[k].test == t) begin
        if (j < outlog.size()) begin
          chk({nm, "_serial"}, outlog[j].serial, vt[k].exp_serial);
          chk({nm, "_src"}, outlog[j].src, vt[k].exp_src);
          chk({nm, "_last"}, outlog[j].last, vt[k].exp_last);
        end
        j++;
      end
    end
  endtask

  task automatic run_directed(input int t, input string nm);
    int cnt;
    cnt = 0;
    foreach (vt[k]) if (vt[k].test == t) cnt++;
    load_test(t);
    out_ready = 1'b1;
    settle();
    run_until(cnt, 40);
    compare_test(t, nm);
  endtask

  initial begin
    int ptr_hold;
    // {test, port, in_serial, in_last, exp_serial, exp_src, exp_last}
    vt.push_back('{1, 0,   0, 0,   0, 0, 0});
    vt.push_back('{1, 1, 100, 0, 100, 1, 0});
    vt.push_back('{1, 0,   1, 0,   1, 0, 0});
    vt.push_back('{1, 1, 101, 0, 101, 1, 0});
    vt.push_back('{1, 0,   2, 0,   2, 0, 0});
    vt.push_back('{1, 1, 102, 0, 102, 1, 0});
    vt.push_back('{1, 0,   3, 0,   3, 0, 0});
    vt.push_back('{1, 1, 103, 0, 103, 1, 0});
    vt.push_back('{2, 0, 200, 0, 200, 0, 0});
    vt.push_back('{2, 1, 300, 0, 300, 1, 0});
    vt.push_back('{2, 0, 201, 0, 201, 0, 0});
    vt.push_back('{2, 1, 301, 0, 301, 1, 0});
    vt.push_back('{2, 0, 202, 0, 202, 0, 0});
    vt.push_back('{2, 1, 302, 0, 302, 1, 0});
    vt.push_back('{3, 1, 400, 0, 400, 1, 0});
    vt.push_back('{3, 1, 401, 0, 401, 1, 0});
    vt.push_back('{3, 1, 402, 0, 402, 1, 0});
    vt.push_back('{3, 1, 403, 0, 403, 1, 0});
    vt.push_back('{4, 0,   5, 1,   5, 0, 0});
    vt.push_back('{4, 0,   6, 0,  50, 1, 0});
    vt.push_back('{4, 1,  50, 0,  51, 1, 0});
    vt.push_back('{4, 1,  51, 0,  52, 1, 1});
    vt.push_back('{4, 1,  52, 1,   6, 0, 0});
    vt.push_back('{5, 0,   7, 1,  70, 1, 0});
    vt.push_back('{5, 1,  70, 1,   7, 0, 1});

    for (int i = 0; i < N; i++) en[i] = 1'b1;
    out_ready = 1'b1;
    mreset();
    settle();

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last_processed, 0);
    chk("rst_out_serial", out_serialnum, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_rr_ptr", dut.rr_ptr, 0);
    chk("rst_done", dut.done_mask, 0);
    resetn = 1'b1;
    settle();

    run_directed(1, "fair");

    // Backpressure: hold one tuple for 5 stalled cycles
    load_test(2);
    out_ready = 1'b1;
    settle();
    tick();
    out_ready = 1'b0;
    settle();
    ptr_hold = mptr;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_rr_ptr", dut.rr_ptr, ptr_hold);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    settle();
    run_until(6, 40);
    compare_test(2, "bp");

    run_directed(3, "single");
    run_directed(4, "eos");
    run_directed(5, "simfinal");
    tick();
    chk("simfinal_done", dut.done_mask, 0);

    // Reset while a tuple is held and the done mask is non-zero
    outlog.delete();
    srcq[0].push_back(mk(800, 0));
    srcq[0].push_back(mk(801, 0));
    srcq[0].push_back(mk(802, 0));
    srcq[1].push_back(mk(900, 1));
    srcq[1].push_back(mk(901, 0));
    srcq[1].push_back(mk(902, 0));
    out_ready = 1'b1;
    settle();
    tick();
    tick();
    tick();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_done", dut.done_mask, 2'b10);
    resetn = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_done", dut.done_mask, 0);
    chk("mid_rst_rr_ptr", dut.rr_ptr, 0);
    mreset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    settle();
    chk("post_rst_grant", in_ready, 2'b01);
    tick();
    chk("post_rst_src", out_src, 0);
    chk("post_rst_serial", out_serialnum, 802);
    for (int c = 0; c < 30 && (srcq[0].size() > 0 || srcq[1].size() > 0 || mv); c++) tick();

    // Randomized traffic against the reference
    begin
      logic [63:0] sctr [N];
      for (int i = 0; i < N; i++) sctr[i] = 64'(i) * 64'd1000000 + 64'd5000;
      for (int c = 0; c < 1500; c++) begin
        for (int i = 0; i < N; i++) begin
          if (srcq[i].size() < 4 && $urandom_range(0, 3) != 0) begin
            tuple_t t;
            t.data = {$urandom, $urandom};
            t.tag = $urandom;
            t.serialnum = sctr[i];
            t.was_joined = 1'($urandom_range(0, 1));
            t.last_processed = ($urandom_range(0, 5) == 0);
            srcq[i].push_back(t);
            sctr[i] = sctr[i] + 1;
          end
          en[i] = ($urandom_range(0, 3) != 0);
        end
        out_ready = ($urandom_range(0, 9) < 7);
        settle();
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
